// File: rtl/watch_pkg.sv
// Shared constants and key-matrix helpers for the watch keypad front end.
package watch_pkg;

    localparam int NUM_DIGITS = 10;
    localparam int NUM_COLS   = 3;
    localparam int NUM_ROWS   = 4;

    localparam logic [3:0] KEY_STAR = 4'd10;
    localparam logic [3:0] KEY_HASH = 4'd11;

    localparam logic [1:0] ST_SCAN     = 2'd0;
    localparam logic [1:0] ST_DEBOUNCE = 2'd1;
    localparam logic [1:0] ST_PRESSED  = 2'd2;

    // True when exactly one row line is pulled low.
    function automatic logic single_low(input logic [NUM_ROWS-1:0] row);
        return $countones(~row) == 1;
    endfunction

    function automatic logic [1:0] low_index(input logic [NUM_ROWS-1:0] row);
        logic [1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_ROWS; i++) begin
            if (!row[i]) idx = 2'(i);
        end
        return idx;
    endfunction

    // Rows 0..2 carry digits 1..9; row 3 is '*', '0', '#'.
    function automatic logic [3:0] key_map(input logic [1:0] row_idx, input logic [1:0] col_idx);
        logic [3:0] code;
        if (row_idx == 2'd3) begin
            case (col_idx)
                2'd0:    code = KEY_STAR;
                2'd1:    code = 4'd0;
                default: code = KEY_HASH;
            endcase
        end else begin
            code = 4'(row_idx) * 4'd3 + 4'(col_idx) + 4'd1;
        end
        return code;
    endfunction

    function automatic logic [NUM_DIGITS-1:0] digit_onehot(input logic [3:0] code);
        logic [NUM_DIGITS-1:0] oh;
        oh = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            oh[i] = (code == 4'(i));
        end
        return oh;
    endfunction

endpackage

// File: rtl/keypad_scanner_stable_counter.sv
// Saturating run-length counter; done flags the DEBOUNCE-th consecutive matching cycle.
module kp_stable_counter #(
    parameter int DEBOUNCE = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic match,
    input  logic clear,
    output logic done
);

    localparam int CW = (DEBOUNCE > 2) ? $clog2(DEBOUNCE) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear || !match) begin
            count <= '0;
        end else if (count != CNT_MAX) begin
            count <= count + 1'b1;
        end
    end

    assign done = match && (count == CNT_MAX);

endmodule

// File: rtl/keypad_scanner.sv
// 3x4 key matrix scanner: column scan, single-key debounce, one-hot digit and function outputs.
module keypad_scanner
    import watch_pkg::*;
#(
    parameter int SCAN_DWELL = 4,
    parameter int DEBOUNCE   = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] key_row,
    output logic [2:0] key_col,
    output logic [9:0] keypad,
    output logic [1:0] key_func,
    output logic [3:0] key_code,
    output logic       key_valid
);

    // state    | meaning
    // SCAN     | rotate columns, sample rows at end of each dwell
    // DEBOUNCE | one key seen, waiting for a stable run on its column
    // PRESSED  | key accepted, outputs held until a stable release

    localparam int DW = $clog2(SCAN_DWELL);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DWELL - 1);

    logic [NUM_ROWS-1:0] row_m;
    logic [NUM_ROWS-1:0] row_s;
    logic [NUM_ROWS-1:0] row_cap;
    logic [1:0]          col_idx;
    logic [1:0]          col_next;
    logic [1:0]          state;
    logic [DW-1:0]       dwell;
    logic [3:0]          code_now;
    logic                cnt_match;
    logic                cnt_clear;
    logic                cnt_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            row_m <= '1;
            row_s <= '1;
        end else begin
            row_m <= key_row;
            row_s <= row_m;
        end
    end

    assign col_next = (col_idx == 2'(NUM_COLS - 1)) ? 2'd0 : col_idx + 2'd1;
    assign key_col  = ~(3'b001 << col_idx);
    assign code_now = key_map(low_index(row_cap), col_idx);

    always_comb begin
        cnt_match = 1'b0;
        case (state)
            ST_DEBOUNCE: cnt_match = (row_s == row_cap);
            ST_PRESSED:  cnt_match = (row_s == '1);
            default:     cnt_match = 1'b0;
        endcase
    end

    // The same counter times both press and release; it restarts on every phase change.
    assign cnt_clear = (state == ST_SCAN) || cnt_done;

    kp_stable_counter #(
        .DEBOUNCE(DEBOUNCE)
    ) u_stable (
        .clk  (clk),
        .rst  (rst),
        .match(cnt_match),
        .clear(cnt_clear),
        .done (cnt_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_SCAN;
            col_idx   <= '0;
            dwell     <= '0;
            row_cap   <= '1;
            keypad    <= '0;
            key_func  <= '0;
            key_code  <= '0;
            key_valid <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            case (state)
                ST_SCAN: begin
                    if (dwell == DWELL_LAST) begin
                        dwell <= '0;
                        if (single_low(row_s)) begin
                            row_cap <= row_s;
                            state   <= ST_DEBOUNCE;
                        end else begin
                            col_idx <= col_next;
                        end
                    end else begin
                        dwell <= dwell + 1'b1;
                    end
                end
                ST_DEBOUNCE: begin
                    if (!cnt_match) begin
                        state   <= ST_SCAN;
                        col_idx <= col_next;
                    end else if (cnt_done) begin
                        state     <= ST_PRESSED;
                        key_code  <= code_now;
                        key_valid <= 1'b1;
                        if (code_now == KEY_STAR) begin
                            key_func <= 2'b01;
                        end else if (code_now == KEY_HASH) begin
                            key_func <= 2'b10;
                        end else begin
                            keypad <= digit_onehot(code_now);
                        end
                    end
                end
                ST_PRESSED: begin
                    if (cnt_done) begin
                        keypad   <= '0;
                        key_func <= '0;
                        col_idx  <= col_next;
                        state    <= ST_SCAN;
                    end
                end
                default: state <= ST_SCAN;
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner: matrix model, expected keys queued at press, checked on key_valid.
module tb_keypad_scanner;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] key_row;
    logic [2:0] key_col;
    logic [9:0] keypad;
    logic [1:0] key_func;
    logic [3:0] key_code;
    logic       key_valid;

    // held[row*3+col] = physical key closed
    logic [11:0] held = '0;

    typedef struct {
        logic [3:0] code;
        logic [9:0] pad;
        logic [1:0] func;
    } exp_t;

    exp_t sb[$];
    int   n_tests    = 0;
    int   n_fail     = 0;
    int   valid_seen = 0;

    keypad_scanner #(
        .SCAN_DWELL(4),
        .DEBOUNCE  (20)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .key_row  (key_row),
        .key_col  (key_col),
        .keypad   (keypad),
        .key_func (key_func),
        .key_code (key_code),
        .key_valid(key_valid)
    );

    always #5 clk = ~clk;

    always_comb begin
        key_row = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 3; c++) begin
                if (held[r*3+c] && !key_col[c]) key_row[r] = 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (key_valid === 1'b1) begin
            exp_t e;
            valid_seen++;
            chk("valid_expected", sb.size() > 0, 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("sb_code", key_code, e.code);
                chk("sb_keypad", keypad, e.pad);
                chk("sb_func", key_func, e.func);
            end
            chk("inv_exclusive", (keypad != 0) && (key_func != 0), 0);
            chk("inv_onehot", $countones(keypad) <= 1, 1);
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_col_entry(input logic [2:0] target);
        int n = 0;
        while (key_col == target && n < 100) begin step(1); n++; end
        while (key_col != target && n < 100) begin step(1); n++; end
        chk("wait_col_timeout", n >= 100, 0);
    endtask

    task automatic wait_valid(input string tag, input int prev, input int budget);
        int n = 0;
        while (valid_seen == prev && n < budget) begin step(1); n++; end
        chk({tag, "_valid_seen"}, valid_seen > prev, 1);
    endtask

    task automatic wait_clear(input string tag, input int budget);
        int n = 0;
        while ((keypad != 0 || key_func != 0) && n < budget) begin step(1); n++; end
        chk({tag, "_released"}, (keypad == 0) && (key_func == 0), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int prev;
        int changes;
        logic [2:0] last_col;

        // reset and column rotation
        rst = 1'b1;
        step(3);
        chk("rst_col", key_col, 3'b110);
        chk("rst_keypad", keypad, 0);
        chk("rst_valid", key_valid, 0);
        chk("rst_func", key_func, 0);
        chk("rst_code", key_code, 0);
        rst = 1'b0;
        step(3);
        chk("rot_col0", key_col, 3'b110);
        step(1);
        chk("rot_col1", key_col, 3'b101);
        step(4);
        chk("rot_col2", key_col, 3'b011);
        step(4);
        chk("rot_wrap", key_col, 3'b110);

        // clean '5' with exact latency
        sb.push_back('{code: 4'd5, pad: 10'b0000100000, func: 2'b00});
        wait_col_entry(3'b101);
        held[4] = 1'b1;
        step(23);
        chk("p5_before_keypad", keypad, 0);
        chk("p5_before_valid", key_valid, 0);
        step(1);
        chk("p5_keypad", keypad, 10'b0000100000);
        chk("p5_valid", key_valid, 1);
        chk("p5_code", key_code, 4'd5);
        step(1);
        chk("p5_valid_once", key_valid, 0);
        chk("p5_hold", keypad, 10'b0000100000);
        chk("p5_col_held", key_col, 3'b101);
        step(70);
        chk("p5_still", keypad, 10'b0000100000);
        held[4] = 1'b0;
        step(21);
        chk("p5_rel_before", keypad, 10'b0000100000);
        step(1);
        chk("p5_rel_keypad", keypad, 0);
        chk("p5_rel_col2", key_col, 3'b011);
        chk("p5_code_kept", key_code, 4'd5);

        // bouncy '0'
        prev = valid_seen;
        wait_col_entry(3'b101);
        for (int i = 0; i < 5; i++) begin
            held[10] = (i % 2 == 0);
            step(3);
        end
        held[10] = 1'b1;
        chk("b0_no_early_valid", valid_seen, prev);
        sb.push_back('{code: 4'd0, pad: 10'b0000000001, func: 2'b00});
        wait_valid("b0", prev, 80);
        step(40);
        chk("b0_single_pulse", valid_seen, prev + 1);
        chk("b0_keypad", keypad, 10'b0000000001);
        held[10] = 1'b0;
        wait_clear("b0", 40);

        // function key '#'
        prev = valid_seen;
        step(5);
        sb.push_back('{code: 4'd11, pad: 10'b0, func: 2'b10});
        held[11] = 1'b1;
        wait_valid("hash", prev, 80);
        chk("hash_func", key_func, 2'b10);
        chk("hash_keypad", keypad, 0);
        chk("hash_code", key_code, 4'd11);
        step(30);
        chk("hash_single", valid_seen, prev + 1);
        held[11] = 1'b0;
        wait_clear("hash", 40);

        // multi-key on column 0 must be ignored
        prev = valid_seen;
        step(5);
        held[0] = 1'b1;
        held[3] = 1'b1;
        step(4);
        changes  = 0;
        last_col = key_col;
        for (int i = 0; i < 48; i++) begin
            step(1);
            if (key_col != last_col) changes++;
            last_col = key_col;
        end
        chk("multi_rotation", changes, 12);
        chk("multi_no_valid", valid_seen, prev);
        chk("multi_keypad", keypad, 0);
        held[0] = 1'b0;
        held[3] = 1'b0;
        step(10);

        // reset in the middle of a '9' press
        prev = valid_seen;
        sb.push_back('{code: 4'd9, pad: 10'b1000000000, func: 2'b00});
        held[8] = 1'b1;
        wait_valid("r9", prev, 80);
        step(5);
        rst = 1'b1;
        step(1);
        chk("r9_rst_keypad", keypad, 0);
        chk("r9_rst_col", key_col, 3'b110);
        chk("r9_rst_valid", key_valid, 0);
        step(2);
        rst = 1'b0;
        prev = valid_seen;
        sb.push_back('{code: 4'd9, pad: 10'b1000000000, func: 2'b00});
        wait_valid("r9_again", prev, 80);
        step(30);
        chk("r9_single_new", valid_seen, prev + 1);
        chk("r9_keypad", keypad, 10'b1000000000);
        held[8] = 1'b0;
        wait_clear("r9", 40);
        step(10);

        chk("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Drives a 3-column x 4-row passive key matrix on the board and reads its rows.
- Debounces one key at a time and outputs it on the 10-bit one-hot digit bus consumed by the watch block's keypad input. Bit n set means digit n is pressed.
- Also reports '*' and '#' on a separate function bus for future mode/edit control.
- Sits between the board key-matrix pins and the watch block, clocked by the same 1 kHz system clock.

Parameters:
- SCAN_DWELL, 4, cycles each column is driven in SCAN state; minimum 3, to cover the 2-flop row synchroniser.
- DEBOUNCE, 20, consecutive stable cycles (20 ms at 1 kHz) needed to accept a press and to accept a release; minimum 2.

Ports:
- clk  input  1  system clock, 1 kHz.
- rst  input  1  synchronous reset, active-high.
- key_row  input  4  matrix rows; active-low, pulled up externally; asynchronous to clk.
- key_col  output  3  matrix column drive; active-low, exactly one bit low at a time.
- keypad  output  10  one-hot digit 0..9; held for the whole debounced press; all-zero otherwise.
- key_func  output  2  bit0='*', bit1='#'; held like keypad.
- key_code  output  4  binary code of the accepted key: 0..9 digits, 10='*', 11='#'; holds the last value.
- key_valid  output  1  one-cycle pulse when a press is accepted.

Behaviour:
- Clock and reset: a single clock; reset is synchronous and active-high. All state updates on the posedge of clk. rst sampled high forces reset on that edge, including in the middle of a press or debounce.
- Reset values: key_col=3'b110 (column 0 driven), keypad=0, key_func=0, key_code=0, key_valid=0, FSM=SCAN, dwell and debounce counters=0, synchroniser flops=4'b1111.
- Row synchroniser: two flops on key_row; only the synchronised value (row_s) is used.
- Key map (row, col):
  - r0: 1 2 3
  - r1: 4 5 6
  - r2: 7 8 9
  - r3: * 0 #
- SCAN state:
  - Dwell counter runs 0..SCAN_DWELL-1 per column.
  - At count SCAN_DWELL-1, sample row_s.
  - all ones: advance column 0->1->2->0 and restart dwell.
  - exactly one bit low: capture row and column, go to DEBOUNCE; the column stays driven.
  - two or more bits low: ghost/multi-key; ignore it and advance the column.
- DEBOUNCE state:
  - Each cycle, if row_s equals the captured pattern, the counter increments; otherwise go to SCAN and advance the column.
  - When the counter reaches DEBOUNCE-1 on a matching cycle, go to PRESSED.
  - On that edge: keypad/key_func are set per the map, key_code is loaded, and key_valid=1 for exactly one cycle.
- PRESSED state:
  - The column stays driven and outputs hold.
  - Any other key pressed in another column is not seen; in the same column it is ignored.
  - row_s all ones for DEBOUNCE consecutive cycles: clear keypad and key_func, advance column, go to SCAN.
  - Any row low during that count resets the counter (release bounce) and outputs stay set.
- Latency: an accepted press asserts keypad exactly DEBOUNCE cycles after the sample edge. Release clears outputs DEBOUNCE cycles after row_s first returns to all ones with no bounce.
- Invariants:
  - keypad and key_func are never both non-zero.
  - keypad is never multi-hot.
  - key_valid never fires twice per physical press.

Decomposition:
- Shared package watch_pkg:
  - key code constants KEY_STAR=4'd10 and KEY_HASH=4'd11.
  - FSM state encoding SCAN/DEBOUNCE/PRESSED.
  - one-hot digit width 10.
  - column count 3 and row count 4.
- One sub-module, kp_stable_counter: a saturating counter with DEBOUNCE parameter, inputs match/clear, output done. It is instantiated once and reused for both the press and release phases.

Test Plan:
- Reset: hold rst 3 cycles -> key_col=110, keypad=0, key_valid=0. Release rst -> key_col rotates 110->101->011 every 4 cycles.
- Clean press '5' (row1 low while col1 driven, held 100 cycles):
  - keypad=10'b0000100000 and key_code=5, 20 cycles after the sample edge.
  - key_valid high 1 cycle.
  - Row released -> keypad=0 after 20 cycles; scan resumes at col2.
- Bouncy press '0' (row3 toggles every 3 cycles for 15 cycles, then stable):
  - No key_valid during the bounce.
  - Exactly one pulse after 20 stable cycles; keypad=10'b0000000001.
- Function key '#' (row3, col2):
  - key_func=2'b10, keypad=0, key_code=11, one key_valid pulse.
- Multi-key (rows 0 and 1 both low on col0):
  - No transition out of SCAN, no key_valid; column keeps rotating.
- Reset mid-press (rst asserted while PRESSED with '9'):
  - Next edge keypad=0, key_col=110.
  - After rst drops with the key still held, a fresh debounce occurs and a single new key_valid fires.
